fetch_pc_gen: RTL and testbench
===============================

// Module: fetch_pc_gen
// PURPOSE
//  Next-fetch-PC sequencer directly downstream of the branch predictor. Holds the current fetch PC and
//  fetch ID, presents them to the predictor/ICache, and each accepted cycle selects the next PC from
//  predicted-taken target, split-block continuation, sequential fall-through or branch-unit redirect.
//  Also enforces the in-flight fetch-ID window against the committed fetch ID.
// PARAMETERS
//  FETCH_BYTES   16      fetch block size in bytes, power of 2; PC blocks aligned to it
//  FID_W         3       FetchID_t width; window holds 2**FID_W-1 in-flight blocks
//  RESET_PC      32'h0   first fetch PC after reset (must be 2-byte aligned)
//  CLEAR_CYCLES  4       fetch hold length after an ICache clear request
// PORTS
//  clk                   in   1      clock
//  rst                   in   1      synchronous reset, ACTIVE-LOW (fetch state reset while rst==0)
//  IN_mispr              in   1      branch-unit redirect
//  IN_misprPC            in   32     redirect target
//  IN_misprFetchID       in   FID_W  fetch ID of mispredicting block
//  IN_clearICache        in   1      start ICache clear hold
//  IN_bpStall            in   1      predictor stall (return-stack busy)
//  IN_ifStall            in   1      fetch-buffer backpressure
//  IN_comFetchID         in   FID_W  oldest uncommitted fetch ID
//  IN_predBr             in   PredBranch  {valid,dst[30:0],offs,isJump,compr}, combinational on OUT_pc
//  IN_branchTaken        in   1      predictor says IN_predBr is taken
//  IN_multipleBranches   in   1      further branch in block after not-taken IN_predBr
//  OUT_pcValid           out  1      OUT_pc/OUT_fetchID valid and consumed this cycle
//  OUT_pc                out  32     current fetch PC
//  OUT_fetchID           out  FID_W  fetch ID of current block
//  OUT_windowFull        out  1      fetch-ID window exhausted
// BEHAVIOUR
//  Reset (rst==0 at edge): pc=RESET_PC, fetchID=0, state=RUN, clearCnt=0; outputs next cycle:
//   OUT_pcValid=0 during reset cycle, OUT_pc=RESET_PC, OUT_fetchID=0, OUT_windowFull=0.
//  States: RUN (fetching), HOLD (no advance: stall or window full), CLEAR (clearCnt counting down).
//  OUT_windowFull = (OUT_fetchID+1 mod 2**FID_W) == IN_comFetchID. Wrap-around is modular.
//  OUT_pcValid = state!=CLEAR && !IN_bpStall && !IN_ifStall && !OUT_windowFull && !IN_mispr; comb.
//  Advance (OUT_pcValid==1), registered, 1-cycle latency to new OUT_pc:
//   base = pc & ~(FETCH_BYTES-1); br = base + 2*IN_predBr.offs
//   taken (IN_predBr.valid && IN_branchTaken): pc <= {IN_predBr.dst,1'b0}
//   else if IN_multipleBranches: pc <= br + (compr ? 2 : 4)  (may cross into next block: allowed)
//   else: pc <= base + FETCH_BYTES (32-bit wrap at 2**32 ignored/allowed)
//   fetchID <= fetchID+1.
//  No advance: pc, fetchID hold; state RUN->HOLD, HOLD->RUN once advance condition true again.
//  Priority per edge: rst > IN_mispr > IN_clearICache > stall/window > advance.
//   IN_mispr: pc <= IN_misprPC, fetchID <= IN_misprFetchID+1; OUT_pcValid=0 this cycle; clearCnt unchanged.
//   IN_clearICache: state<=CLEAR, clearCnt<=CLEAR_CYCLES-1; pc/fetchID hold; re-assert restarts count.
//   CLEAR: decrement each cycle; at 0 -> RUN. Mispr during CLEAR updates pc/fetchID, stays CLEAR.
//  Reset mid-CLEAR or mid-HOLD: all state discarded, RUN at RESET_PC.
//  Predictor inputs sampled only when OUT_pcValid; X on IN_predBr when invalid must not propagate.
// STRUCTURE
//  Shared package: FetchID_t, PredBranch (existing); add FetchPCState_t enum {RUN,HOLD,CLEAR}.
//  One natural sub-module: fetch_next_pc (combinational next-PC mux + adders); rest in top FSM.
// TESTING
//  Reset: hold rst=0 3 cycles, release -> OUT_pc=RESET_PC, OUT_fetchID=0, OUT_pcValid=1 next cycle.
//  Sequential: pc=0x1004, no branch, 3 cycles -> OUT_pc 0x1010,0x1020,0x1030; fetchID 1,2,3.
//  Taken/split: pc=0x2000, predBr{offs=3,dst=0x2400>>1} taken -> 0x2400; same not-taken+multiple,
//   compr=0 -> 0x200A; compr=1 -> 0x2008.
//  Window: comFetchID=0, fetchID reaches 7 -> OUT_windowFull=1, OUT_pcValid=0; comFetchID=1 -> resumes.
//  Mispr+stall same cycle: misprPC=0x8000, misprFetchID=5, IN_ifStall=1 -> next OUT_pc=0x8000, fetchID=6.
//  Clear: IN_clearICache pulse -> OUT_pcValid=0 exactly CLEAR_CYCLES cycles, pc unchanged, then resume.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch-stage types: fetch IDs, predictor branch record, PC sequencer states.
package fetch_pc_gen_pkg;

  localparam int unsigned FETCH_BYTES_DEF = 16;
  localparam int unsigned FID_W_DEF       = 3;
  // Branch offset counts halfwords within one fetch block.
  localparam int unsigned OFFS_W          = $clog2(FETCH_BYTES_DEF) - 1;

  typedef logic [FID_W_DEF-1:0] FetchID_t;

  typedef struct packed {
    logic              valid;
    logic [30:0]       dst;
    logic [OFFS_W-1:0] offs;
    logic              isJump;
    logic              compr;
  } PredBranch;

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    CLEAR
  } FetchPCState_t;

  function automatic logic [31:0] block_base(input logic [31:0] pc, input int unsigned bytes);
    logic [31:0] mask;
    mask = 32'(bytes) - 32'd1;
    return pc & ~mask;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-fetch-PC select: taken target, split-block continuation or fall-through.
module fetch_next_pc
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned FETCH_BYTES = FETCH_BYTES_DEF
) (
  input  logic        en,
  input  logic [31:0] pc,
  input  PredBranch   pred_br,
  input  logic        branch_taken,
  input  logic        multiple_branches,
  output logic [31:0] next_pc
);

  PredBranch   pb;
  logic        taken;
  logic        multi;
  logic [31:0] base;
  logic [31:0] br;
  logic        unused_is_jump;

  assign unused_is_jump = pred_br.isJump;

  always_comb begin
    // Predictor fields are masked when not consumed so unknowns never reach the PC mux.
    pb    = en ? pred_br : '0;
    taken = en & branch_taken;
    multi = en & multiple_branches;

    base  = block_base(pc, FETCH_BYTES);
    br    = base + {{(31 - OFFS_W){1'b0}}, pb.offs, 1'b0};

    next_pc = base + 32'(FETCH_BYTES);
    if (pb.valid && taken) begin
      next_pc = {pb.dst, 1'b0};
    end else if (multi) begin
      next_pc = br + (pb.compr ? 32'd2 : 32'd4);
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC / fetch ID sequencer with redirect, ICache-clear hold and fetch-ID window control.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned FETCH_BYTES  = FETCH_BYTES_DEF,
  parameter int unsigned FID_W        = FID_W_DEF,
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_mispr,
  input  logic [31:0]      IN_misprPC,
  input  logic [FID_W-1:0] IN_misprFetchID,
  input  logic             IN_clearICache,
  input  logic             IN_bpStall,
  input  logic             IN_ifStall,
  input  logic [FID_W-1:0] IN_comFetchID,
  input  PredBranch        IN_predBr,
  input  logic             IN_branchTaken,
  input  logic             IN_multipleBranches,
  output logic             OUT_pcValid,
  output logic [31:0]      OUT_pc,
  output logic [FID_W-1:0] OUT_fetchID,
  output logic             OUT_windowFull
);

  localparam int unsigned CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  logic [31:0]      pc;
  logic [FID_W-1:0] fetch_id;
  FetchPCState_t    state;
  logic [CNT_W-1:0] clear_cnt;
  logic [31:0]      next_pc;
  logic             window_full;
  logic             pc_valid;

  always_comb begin
    window_full = (fetch_id + FID_W'(1)) == IN_comFetchID;
    // A clear request wins over advance, so the block is not reported as consumed that cycle.
    pc_valid    = rst && (state != CLEAR) && !IN_bpStall && !IN_ifStall &&
                  !window_full && !IN_mispr && !IN_clearICache;
  end

  fetch_next_pc #(
    .FETCH_BYTES(FETCH_BYTES)
  ) u_next_pc (
    .en               (pc_valid),
    .pc               (pc),
    .pred_br          (IN_predBr),
    .branch_taken     (IN_branchTaken),
    .multiple_branches(IN_multipleBranches),
    .next_pc          (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= RESET_PC;
      fetch_id  <= '0;
      state     <= RUN;
      clear_cnt <= '0;
    end else if (IN_mispr) begin
      pc       <= IN_misprPC;
      fetch_id <= IN_misprFetchID + FID_W'(1);
      if (state != CLEAR) begin
        state <= RUN;
      end
    end else if (IN_clearICache) begin
      state     <= (CLEAR_CYCLES > 1) ? CLEAR : RUN;
      clear_cnt <= CNT_W'(CLEAR_CYCLES - 1);
    end else if (state == CLEAR) begin
      // Request cycle plus CLEAR_CYCLES-1 counted cycles gives the full hold length.
      if (clear_cnt <= CNT_W'(1)) begin
        state     <= RUN;
        clear_cnt <= '0;
      end else begin
        clear_cnt <= clear_cnt - CNT_W'(1);
      end
    end else if (pc_valid) begin
      pc       <= next_pc;
      fetch_id <= fetch_id + FID_W'(1);
      state    <= RUN;
    end else begin
      state <= HOLD;
    end
  end

  always_comb begin
    OUT_pcValid    = pc_valid;
    OUT_pc         = pc;
    OUT_fetchID    = fetch_id;
    OUT_windowFull = window_full;
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: reset, sequential, branch select, window, redirect, clear hold.
module tb_fetch_pc_gen;
  import fetch_pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        IN_mispr;
  logic [31:0] IN_misprPC;
  logic [2:0]  IN_misprFetchID;
  logic        IN_clearICache;
  logic        IN_bpStall;
  logic        IN_ifStall;
  logic [2:0]  IN_comFetchID;
  PredBranch   IN_predBr;
  logic        IN_branchTaken;
  logic        IN_multipleBranches;
  logic        OUT_pcValid;
  logic [31:0] OUT_pc;
  logic [2:0]  OUT_fetchID;
  logic        OUT_windowFull;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  fetch_pc_gen #(
    .FETCH_BYTES (16),
    .FID_W       (3),
    .RESET_PC    (32'h0),
    .CLEAR_CYCLES(4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .IN_mispr           (IN_mispr),
    .IN_misprPC         (IN_misprPC),
    .IN_misprFetchID    (IN_misprFetchID),
    .IN_clearICache     (IN_clearICache),
    .IN_bpStall         (IN_bpStall),
    .IN_ifStall         (IN_ifStall),
    .IN_comFetchID      (IN_comFetchID),
    .IN_predBr          (IN_predBr),
    .IN_branchTaken     (IN_branchTaken),
    .IN_multipleBranches(IN_multipleBranches),
    .OUT_pcValid        (OUT_pcValid),
    .OUT_pc             (OUT_pc),
    .OUT_fetchID        (OUT_fetchID),
    .OUT_windowFull     (OUT_windowFull)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic redirect(input logic [31:0] target, input logic [2:0] fid);
    IN_mispr        = 1'b1;
    IN_misprPC      = target;
    IN_misprFetchID = fid;
    tick();
    IN_mispr = 1'b0;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] seq_pc [3];
    seq_pc[0] = 32'h1010;
    seq_pc[1] = 32'h1020;
    seq_pc[2] = 32'h1030;

    rst = 1'b0;
    IN_mispr = 1'b0; IN_misprPC = '0; IN_misprFetchID = '0;
    IN_clearICache = 1'b0; IN_bpStall = 1'b0; IN_ifStall = 1'b0;
    IN_comFetchID = '0; IN_predBr = '0; IN_branchTaken = 1'b0; IN_multipleBranches = 1'b0;

    // Reset held three cycles, then released.
    tick(); tick(); tick();
    settle();
    check("rst_valid", 32'(OUT_pcValid), 32'd0);
    rst = 1'b1;
    settle();
    check("rst_pc", OUT_pc, 32'h0);
    check("rst_fid", 32'(OUT_fetchID), 32'd0);
    check("rst_wfull", 32'(OUT_windowFull), 32'd0);
    check("rst_valid_after", 32'(OUT_pcValid), 32'd1);

    // Sequential fall-through from an unaligned PC.
    IN_comFetchID   = 3'd5;
    IN_mispr        = 1'b1;
    IN_misprPC      = 32'h1004;
    IN_misprFetchID = 3'd7;
    settle();
    check("mispr_valid", 32'(OUT_pcValid), 32'd0);
    tick();
    IN_mispr = 1'b0;
    settle();
    check("seq_start_pc", OUT_pc, 32'h1004);
    check("seq_start_fid", 32'(OUT_fetchID), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq_pc", OUT_pc, seq_pc[i]);
      check("seq_fid", 32'(OUT_fetchID), 32'(i + 1));
    end

    // Backpressure and predictor stall hold the PC.
    IN_ifStall = 1'b1;
    settle();
    check("ifstall_valid", 32'(OUT_pcValid), 32'd0);
    tick();
    check("ifstall_pc", OUT_pc, 32'h1030);
    check("ifstall_fid", 32'(OUT_fetchID), 32'd3);
    IN_ifStall = 1'b0;
    IN_bpStall = 1'b1;
    settle();
    check("bpstall_valid", 32'(OUT_pcValid), 32'd0);
    tick();
    check("bpstall_pc", OUT_pc, 32'h1030);
    IN_bpStall = 1'b0;

    // Predicted-taken branch.
    redirect(32'h2000, 3'd7);
    IN_predBr.valid  = 1'b1;
    IN_predBr.dst    = 31'h1200;
    IN_predBr.offs   = 3'd3;
    IN_predBr.isJump = 1'b0;
    IN_predBr.compr  = 1'b0;
    IN_branchTaken   = 1'b1;
    tick();
    check("taken_pc", OUT_pc, 32'h2400);
    check("taken_fid", 32'(OUT_fetchID), 32'd1);

    // Not-taken with a further branch: continue after the 4-byte branch.
    redirect(32'h2000, 3'd7);
    IN_branchTaken      = 1'b0;
    IN_multipleBranches = 1'b1;
    tick();
    check("split4_pc", OUT_pc, 32'h200A);

    // Same with a compressed branch.
    redirect(32'h2000, 3'd7);
    IN_predBr.compr = 1'b1;
    tick();
    check("split2_pc", OUT_pc, 32'h2008);

    // Valid but not-taken, no further branch: plain fall-through.
    redirect(32'h2000, 3'd7);
    IN_multipleBranches = 1'b0;
    tick();
    check("nottaken_pc", OUT_pc, 32'h2010);

    // Garbage predictor inputs while stalled must not move the PC.
    IN_ifStall          = 1'b1;
    IN_predBr           = 'x;
    IN_branchTaken      = 1'bx;
    IN_multipleBranches = 1'bx;
    tick();
    check("xpred_pc", OUT_pc, 32'h2010);
    IN_ifStall          = 1'b0;
    IN_predBr           = '0;
    IN_branchTaken      = 1'b0;
    IN_multipleBranches = 1'b0;

    // Fetch-ID window exhaustion and release.
    IN_comFetchID = 3'd0;
    redirect(32'h3000, 3'd7);
    repeat (7) tick();
    check("wfull_flag", 32'(OUT_windowFull), 32'd1);
    check("wfull_valid", 32'(OUT_pcValid), 32'd0);
    check("wfull_fid", 32'(OUT_fetchID), 32'd7);
    check("wfull_pc", OUT_pc, 32'h3070);
    tick();
    check("wfull_hold_pc", OUT_pc, 32'h3070);
    IN_comFetchID = 3'd1;
    settle();
    check("wfree_flag", 32'(OUT_windowFull), 32'd0);
    check("wfree_valid", 32'(OUT_pcValid), 32'd1);
    tick();
    check("wwrap_fid", 32'(OUT_fetchID), 32'd0);
    check("wwrap_pc", OUT_pc, 32'h3080);

    // Redirect together with a stall.
    IN_ifStall      = 1'b1;
    IN_mispr        = 1'b1;
    IN_misprPC      = 32'h8000;
    IN_misprFetchID = 3'd5;
    settle();
    check("mstall_valid", 32'(OUT_pcValid), 32'd0);
    tick();
    IN_mispr   = 1'b0;
    IN_ifStall = 1'b0;
    settle();
    check("mstall_pc", OUT_pc, 32'h8000);
    check("mstall_fid", 32'(OUT_fetchID), 32'd6);

    // ICache clear hold length.
    IN_clearICache = 1'b1;
    settle();
    n = 0;
    while (OUT_pcValid == 1'b0 && n < 20) begin
      n++;
      check("clear_pc_hold", OUT_pc, 32'h8000);
      tick();
      IN_clearICache = 1'b0;
      settle();
    end
    check("clear_len", 32'(n), 32'd4);
    check("clear_end_pc", OUT_pc, 32'h8000);
    check("clear_end_fid", 32'(OUT_fetchID), 32'd6);

    // Redirect during clear keeps clearing and freezes the count.
    IN_clearICache = 1'b1;
    settle();
    tick();
    IN_clearICache  = 1'b0;
    IN_mispr        = 1'b1;
    IN_misprPC      = 32'h9000;
    IN_misprFetchID = 3'd2;
    tick();
    IN_mispr = 1'b0;
    settle();
    check("clrmis_pc", OUT_pc, 32'h9000);
    check("clrmis_fid", 32'(OUT_fetchID), 32'd3);
    n = 0;
    while (OUT_pcValid == 1'b0 && n < 20) begin
      n++;
      tick();
    end
    check("clrmis_len", 32'(n), 32'd3);

    // Reset in the middle of a clear hold.
    IN_comFetchID  = 3'd0;
    IN_clearICache = 1'b1;
    settle();
    tick();
    IN_clearICache = 1'b0;
    rst = 1'b0;
    settle();
    check("rstclr_valid_low", 32'(OUT_pcValid), 32'd0);
    tick();
    rst = 1'b1;
    settle();
    check("rstclr_pc", OUT_pc, 32'h0);
    check("rstclr_fid", 32'(OUT_fetchID), 32'd0);
    check("rstclr_valid", 32'(OUT_pcValid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
